// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_sequencer
//  Purpose  : Fetch / execute sequencer for a small CPU. Requests instruction
//             words from program memory, holds them in the instruction
//             register for an external decoder, gates register and status
//             writes into a single write-back cycle, and advances the PC.
//             Supports free-running, single-step and halt control.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   step,
    input  logic                   halt_req,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   dec_wr_en,
    input  logic                   dec_stat_wr_en,
    input  logic                   dec_cnt_wr_en,
    input  logic                   dec_add_offset,
    input  logic [PC_WIDTH-1:0]    dec_literal_adr,
    output logic                   reg_wr_en,
    output logic                   stat_wr_en,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [2:0]             state,
    output logic                   busy,
    output logic                   halted,
    output logic                   mem_err,
    output logic                   illegal_op,
    output logic [15:0]            instr_count
);

    localparam int            C_TW           = $clog2(MEM_TIMEOUT + 1);
    localparam logic [C_TW-1:0] C_TIMEOUT_LAST = C_TW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_EXEC  = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t            cur_state;
    state_t            nxt_state;
    logic [C_TW-1:0]   wait_cnt;
    logic              single_step;
    logic              halt_pend;
    logic [4:0]        opcode;
    logic              op_illegal;
    logic              halt_now;
    logic              wait_expired;

    assign opcode       = instruction[INSTR_WIDTH-1 -: 5];
    // Unassigned opcode ranges: 0_1010..0_1111 and 1_0110..1_1111
    assign op_illegal   = ((opcode >= 5'h0A) && (opcode <= 5'h0F)) || (opcode >= 5'h16);
    assign halt_now     = halt_req | halt_pend;
    // Last permitted WAIT cycle: no ack now means the memory has timed out
    assign wait_expired = (wait_cnt == C_TIMEOUT_LAST);
    assign state        = cur_state;
    assign imem_addr    = pc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic and per-state strobes
    always_comb begin
        nxt_state  = cur_state;
        imem_req   = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        reg_wr_en  = 1'b0;
        stat_wr_en = 1'b0;
        case (cur_state)
            S_IDLE: begin
                if (run || step) begin
                    nxt_state = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req  = 1'b1;
                busy      = 1'b1;
                nxt_state = S_WAIT;
            end
            S_WAIT: begin
                imem_req = 1'b1;
                busy     = 1'b1;
                if (imem_ack) begin
                    nxt_state = S_EXEC;
                end else if (wait_expired) begin
                    nxt_state = S_HALT;
                end
            end
            S_EXEC: begin
                busy      = 1'b1;
                nxt_state = op_illegal ? S_HALT : S_WB;
            end
            S_WB: begin
                busy       = 1'b1;
                reg_wr_en  = dec_wr_en;
                stat_wr_en = dec_stat_wr_en;
                if (halt_now) begin
                    nxt_state = S_HALT;
                end else if (single_step || !run) begin
                    nxt_state = S_IDLE;
                end else begin
                    nxt_state = S_FETCH;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (!run && !step && !halt_req) begin
                    nxt_state = S_IDLE;
                end
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase
    end

    // Datapath: IR load, timeout counter, PC, retire counter, mode and error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            instruction <= '0;
            instr_count <= '0;
            wait_cnt    <= '0;
            single_step <= 1'b0;
            halt_pend   <= 1'b0;
            mem_err     <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            // A halt request before write-back is held until the instruction retires
            if (halt_req && (cur_state != S_WB) && (cur_state != S_HALT)) begin
                halt_pend <= 1'b1;
            end
            case (cur_state)
                S_IDLE: begin
                    if (run || step) begin
                        single_step <= step;
                    end
                end
                S_FETCH: begin
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        instruction <= imem_data;
                    end else if (wait_expired) begin
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + C_TW'(1);
                    end
                end
                S_EXEC: begin
                    if (op_illegal) begin
                        illegal_op <= 1'b1;
                    end
                end
                S_WB: begin
                    if (dec_cnt_wr_en) begin
                        pc <= dec_add_offset ? (pc + dec_literal_adr) : dec_literal_adr;
                    end else begin
                        pc <= pc + PC_WIDTH'(1);
                    end
                    instr_count <= instr_count + 16'd1;
                    single_step <= 1'b0;
                    halt_pend   <= 1'b0;
                end
                S_HALT: begin
                    single_step <= 1'b0;
                    halt_pend   <= 1'b0;
                    if (nxt_state == S_IDLE) begin
                        mem_err    <= 1'b0;
                        illegal_op <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
